// File: rtl/counter_pkg.sv
// Shared definitions for the counter lab blocks: state encoding, default width
// and the count value on which a down-counter expires.
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int CNT_W    = 4;
    localparam int TERM_VAL = 1;

endpackage

// File: rtl/down_cnt_timer.sv
// Loadable down-counter/timer with a one-cycle terminal-count pulse.
// Define DOWN_CNT_AUTO_RELOAD_EN to restart from the last loaded value on expiry.
module down_cnt_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             stop,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             tc
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERM_VAL);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;

`ifdef DOWN_CNT_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves
        // it unassigned; that is what keeps this block free of latches.
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
`ifdef DOWN_CNT_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif

        if (load) begin
            // A load restarts the timer and suppresses a coincident expiry.
            cnt_d   = load_val;
            state_d = (load_val != '0) ? RUN : IDLE;
`ifdef DOWN_CNT_AUTO_RELOAD_EN
            reload_d = load_val;
`endif
        end else if (stop) begin
            state_d = IDLE;
        end else if (state_q == RUN && en) begin
            if (cnt_q == TERM) begin
                tc_d = 1'b1;
`ifdef DOWN_CNT_AUTO_RELOAD_EN
                cnt_d = reload_q;
`else
                cnt_d   = '0;
                state_d = IDLE;
`endif
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
        end
    end

`ifdef DOWN_CNT_AUTO_RELOAD_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign cnt  = cnt_q;
    assign busy = (state_q == RUN);
    assign tc   = tc_q;

endmodule

// File: tb/tb_down_cnt_timer.sv
// Scoreboard bench for down_cnt_timer: a timer model predicts every cycle's
// outputs, a monitor compares them at the falling edge. Honours DOWN_CNT_AUTO_RELOAD_EN.
module tb_down_cnt_timer;

    localparam int W = 4;

    logic         clk;
    logic         clr_n;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         stop;
    logic [W-1:0] cnt;
    logic         busy;
    logic         tc;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // Expected {cnt, busy, tc} for each rising edge, oldest first.
    logic [31:0] exp_q[$];

    // Timer model: 'left' is how many enabled edges remain until expiry.
    int  m_left;
    int  m_period;
    bit  m_active;
    bit  m_tc;

    down_cnt_timer #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .stop     (stop),
        .cnt      (cnt),
        .busy     (busy),
        .tc       (tc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests_run);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int c, input bit b, input bit t);
        logic [W-1:0] cw;
        cw = W'(c);
        return 32'({cw, b, t});
    endfunction

    task automatic model_reset();
        m_left   = 0;
        m_period = 0;
        m_active = 0;
        m_tc     = 0;
    endtask

    // Apply one rising edge of the timer rules to the model.
    task automatic model_edge(input bit e, input bit ld, input int v, input bit st);
        m_tc = 0;
        if (!clr_n) begin
            model_reset();
        end else if (ld) begin
            m_period = v;
            m_left   = v;
            m_active = (v != 0);
        end else if (st) begin
            m_active = 0;
        end else if (m_active && e) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_tc = 1;
`ifdef DOWN_CNT_AUTO_RELOAD_EN
                m_left = m_period;
`else
                m_active = 0;
`endif
            end
        end
    endtask

    // Drive inputs for one edge, predict its outcome, push the expectation.
    task automatic step(input bit e, input bit ld, input int v, input bit st);
        en       = e;
        load     = ld;
        load_val = W'(v);
        stop     = st;
        @(posedge clk);
        model_edge(e, ld, v, st);
        exp_q.push_back(pack(m_left, m_active, m_tc));
        #1;
    endtask

    // Monitor: the DUT presents a result after every edge; compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check($sformatf("cyc%0d cnt/busy/tc", cyc), pack(int'(cnt), busy, tc), e);
                cyc++;
            end
        end
    end

    initial begin
        int v;
        clr_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        load_val = '0;
        stop     = 1'b0;
        model_reset();

        // Reset dominates a load request.
        #2;
        check("async reset state", pack(int'(cnt), busy, tc), pack(0, 0, 0));
        step(1, 1, 9, 0);
        step(1, 1, 9, 0);
        @(negedge clk);
        clr_n = 1'b1;

        // Basic countdown from 3.
        step(1, 1, 3, 0);
        repeat (4) step(1, 0, 0, 0);

        // Pause pattern.
        step(1, 1, 5, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0);

        // Zero load stays idle; full-scale load runs 15 edges.
        step(1, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 15, 0);
        repeat (16) step(1, 0, 0, 0);
        step(0, 0, 0, 1);

        // Load at the terminal edge wins; stop at cnt=1 holds the count.
        step(1, 1, 2, 0);
        step(1, 0, 0, 0);
        step(1, 1, 4, 0);
        repeat (3) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 1, 6, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);

        // Asynchronous reset in the middle of a run.
        step(1, 1, 4, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        @(negedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        check("mid-run reset cnt/busy/tc", pack(int'(cnt), busy, tc), pack(0, 0, 0));
        model_reset();
        #1;
        clr_n = 1'b1;
        repeat (3) step(1, 0, 0, 0);

`ifdef DOWN_CNT_AUTO_RELOAD_EN
        // Periodic expiry every 3 enabled edges, then stop holds the count.
        step(1, 1, 3, 0);
        repeat (10) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
`endif

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0:       v = 0;
                1:       v = (1 << W) - 1;
                default: v = int'($urandom_range(1, (1 << W) - 1));
            endcase
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, v,
                 $urandom_range(0, 39) == 0);
        end

        @(negedge clk);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
